sat_mux_ctrl: RTL
=================

SAT_MUX_CTRL -- requirements
Module: sat_mux_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: data path width.
REQ-002 SHALL have parameter LW, default 4: saturation length field width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 pass request; held until granted.
REQ-006 data0  input  DW  requester 0 data, sampled in the cycle of grant.
REQ-007 req1  input  1  requester 1 pass request; held until granted.
REQ-008 data1  input  DW  requester 1 data, sampled in the cycle of grant.
REQ-009 sat_req  input  1  request to force output to all-ones.
REQ-010 arm  input  1  saturation enable; sat_req is honoured only when arm=1.
REQ-011 sat_len  input  LW  burst length minus one, sampled when SAT is entered.
REQ-012 y  output  DW  registered output data.
REQ-013 y_valid  output  1  y carries valid data this cycle.
REQ-014 gnt0, gnt1  output  1 each  registered one-cycle grant pulses, coincident with the matching y.
REQ-015 sat_active  output  1  high while y is forced to all-ones.
REQ-016 sat_count  output  8  count of completed saturation bursts; saturates at 255.

Function
REQ-017 FSM states SHALL be IDLE, SAT and RECOVER.
REQ-018 IDLE priority SHALL be: (sat_req & arm) first, then the pass arbitration.
REQ-019 IDLE with sat_req=1 and arm=1: next state SAT, counter loaded with sat_len, no grant issued.
REQ-020 IDLE pass arbitration: exactly one requester granted per cycle.
  - Grant is round-robin, with priority to the requester not granted last.
  - The pointer updates only on a grant.
REQ-021 Grant to requester k: next cycle y=datak, y_valid=1, gntk=1; 1-cycle latency from request sampling to output.
REQ-022 IDLE with no request: next cycle y_valid=0, gnt0=gnt1=0, and y holds its previous value.
REQ-023 SAT: y=all-ones, y_valid=1, sat_active=1 for exactly sat_len+1 consecutive cycles.
  - sat_len=0 gives one cycle.
  - The counter decrements each cycle; SAT exits to RECOVER after the cycle in which the counter is 0.
REQ-024 In SAT, req0/req1 SHALL be ignored (no grant, no loss).
  - sat_req and sat_len changes SHALL have no effect until the next IDLE.
REQ-025 arm=0 sampled during SAT: SAT SHALL abort; next cycle is RECOVER, and sat_count is not incremented.
REQ-026 Normal SAT completion: sat_count SHALL increment by 1, stopping at 255.
REQ-027 RECOVER SHALL last exactly one cycle with y_valid=0, sat_active=0 and no grants, then go to IDLE.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously.
  - gntk=1 SHALL imply y_valid=1 and sat_active=0.

Reset
REQ-029 rst_n=0 SHALL immediately force:
  - state IDLE, y=0, y_valid=0, gnt0=gnt1=0;
  - sat_active=0, sat_count=0;
  - round-robin priority to requester 0.
REQ-030 Reset asserted mid-SAT or mid-grant SHALL discard the operation; no grant or burst resumes after release.
REQ-031 First rising edge after rst_n deasserts SHALL be treated as a normal IDLE cycle.

Verification
REQ-032 Reset, then req0=1 with data0=16'h1234 for one cycle -> next cycle y=16'h1234, y_valid=1, gnt0=1.
REQ-033 req0 and req1 held high with data0=16'hAAAA, data1=16'h5555 for 4 cycles -> y sequence AAAA, 5555, AAAA, 5555, with gnt alternating 0,1,0,1.
REQ-034 arm=1, sat_req=1, sat_len=3, req0 held high -> y=16'hFFFF with sat_active=1 for 4 cycles, then 1 cycle y_valid=0, then gnt0=1; sat_count=1.
REQ-035 arm=1, sat_len=7, arm dropped on the 3rd SAT cycle -> SAT ends and RECOVER follows; sat_count unchanged.
REQ-036 rst_n pulsed low during SAT -> all outputs 0 asynchronously; after release with no requests, y_valid stays 0.
REQ-037 256 back-to-back completed bursts with sat_len=0 -> sat_count=255 and held at 255.

Source files
------------

// File: rtl/sat_mux_ctrl.sv
// Two-requester round-robin pass mux with an armed all-ones saturation burst.
// IDLE arbitrates; SAT forces y to all-ones for sat_len+1 cycles; RECOVER is one dead cycle.
module sat_mux_ctrl #(
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  input  logic          sat_req,
  input  logic          arm,
  input  logic [LW-1:0] sat_len,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sat_active,
  output logic [7:0]    sat_count,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAT     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state;
  logic [LW-1:0] cnt;
  logic          prio;   // 0: requester 0 wins a tie, 1: requester 1 wins
  logic          pick0;
  logic          pick1;

  assign dbg_state = state;

  // Handshake: reqk is held until gntk pulses; the grant pulse and datak
  // (sampled on the granting edge) appear together on the cycle after the grant.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (req0 && (!req1 || !prio)) pick0 = 1'b1;
    else if (req1)                pick1 = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      prio       <= 1'b0;
      y          <= '0;
      y_valid    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sat_active <= 1'b0;
      sat_count  <= 8'd0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (sat_req && arm) begin
            state      <= SAT;
            cnt        <= sat_len;
            y          <= '1;
            y_valid    <= 1'b1;
            sat_active <= 1'b1;
          end else begin
            y_valid <= pick0 | pick1;
            if (pick0) begin
              y    <= data0;
              gnt0 <= 1'b1;
              prio <= 1'b1;
            end else if (pick1) begin
              y    <= data1;
              gnt1 <= 1'b1;
              prio <= 1'b0;
            end
          end
        end
        SAT: begin
          if (!arm || cnt == '0) begin
            state      <= RECOVER;
            y_valid    <= 1'b0;
            sat_active <= 1'b0;
            if (arm && sat_count != 8'hFF) sat_count <= sat_count + 8'd1;
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        RECOVER: begin
          // The dead cycle is the one spent in RECOVER; its closing edge already
          // arbitrates passes (never saturation) so a waiting requester lands next.
          state   <= IDLE;
          y_valid <= pick0 | pick1;
          if (pick0) begin
            y    <= data0;
            gnt0 <= 1'b1;
            prio <= 1'b1;
          end else if (pick1) begin
            y    <= data1;
            gnt1 <= 1'b1;
            prio <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          y_valid    <= 1'b0;
          sat_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
